// File: rtl/bit_serial_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_pkg
// Shared types for the bit-serial sequencer: opcode and phase encodings, the
// control-strobe payload, and a decode helper.
// Optional feature macro (used by bit_serial_seq): BIT_SERIAL_STEP_EN
// -----------------------------------------------------------------------------
package bit_serial_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned PHASE_W  = 2;

    // 10? decodes to ADD; both encodings are named so the enum covers the space
    typedef enum logic [OPCODE_W-1:0] {
        OP_WAITS   = 3'b000,
        OP_NOP     = 3'b001,
        OP_MULD    = 3'b010,
        OP_MULN    = 3'b011,
        OP_ADD     = 3'b100,
        OP_ADD_ALT = 3'b101,
        OP_WAITR   = 3'b110,
        OP_LDX     = 3'b111
    } opcode_e;

    typedef enum logic [PHASE_W-1:0] {
        P0       = 2'd0,
        P1_ALIGN = 2'd1,
        P2_ACC   = 2'd2
    } phase_e;

    // Control strobes driven towards the datapath
    typedef struct packed {
        logic mux;
        logic muxalu;
        logic gpr_shift;
        logic gpr_write;
        logic acc_shift;
        logic acc_write;
        logic pcincr;
    } ctrl_t;

    // Opcodes that run the bit counter (everything else completes in place)
    function automatic logic is_counting(input opcode_e op);
        return (op == OP_MULD) || (op == OP_MULN) || (op == OP_ADD) ||
               (op == OP_ADD_ALT) || (op == OP_LDX);
    endfunction

endpackage

// File: rtl/bit_serial_seq_if.sv
// -----------------------------------------------------------------------------
// bit_serial_seq_if
// Instruction/handshake inputs and control outputs of the bit-serial sequencer.
//   master : drives i_instr / i_start, observes the control outputs
//   slave  : the sequencer itself
// Parameter DATA_W sets the bit-select width ($clog2(DATA_W)).
// -----------------------------------------------------------------------------
interface bit_serial_seq_if
    import bit_serial_pkg::*;
#(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [OPCODE_W-1:0] i_instr;
    logic                i_start;
    logic [CNT_W-1:0]    o_con_bitsel;
    logic                o_con_mux;
    logic                o_con_muxalu;
    logic                o_con_gpr_shift;
    logic                o_con_gpr_write;
    logic                o_con_acc_shift;
    logic                o_con_acc_write;
    logic                o_con_pcincr;
    logic                o_busy;
    logic [PHASE_W-1:0]  o_phase;

    modport master (
        output i_instr, i_start,
        input  o_con_bitsel, o_con_mux, o_con_muxalu, o_con_gpr_shift,
               o_con_gpr_write, o_con_acc_shift, o_con_acc_write,
               o_con_pcincr, o_busy, o_phase
    );

    modport slave (
        input  i_instr, i_start,
        output o_con_bitsel, o_con_mux, o_con_muxalu, o_con_gpr_shift,
               o_con_gpr_write, o_con_acc_shift, o_con_acc_write,
               o_con_pcincr, o_busy, o_phase
    );

endinterface

// File: rtl/bit_serial_cnt.sv
// -----------------------------------------------------------------------------
// bit_serial_cnt
// Bit counter with async reset, synchronous clear and enable. Wraps to 0 when
// enabled on the terminal value.
//   i_clk, i_rst  : clock, async active-high reset
//   i_clr         : synchronous clear (priority over enable)
//   i_en          : advance the count this cycle
//   i_term_val    : terminal count value
//   o_count       : current count
//   o_term        : count equals terminal value
// -----------------------------------------------------------------------------
module bit_serial_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_term
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_term  = (count_q == i_term_val);
    assign o_count = count_q;

    // Next count: clear, wrap at terminal, or increment
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = o_term ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bit_serial_seq.sv
// -----------------------------------------------------------------------------
// bit_serial_seq
// Control sequencer for the bit-serial datapath. Decodes the 3-bit opcode and
// runs a phase FSM (P0 / P1_ALIGN / P2_ACC) plus an internal bit counter to
// produce the mux, ALU-mux, GPR/ACC shift/write and PC-increment strobes.
// All control outputs are combinational from phase, count, opcode and start,
// and are forced low while i_rst is high.
//   i_clk, i_rst : clock, async active-high reset
//   i_step       : (BIT_SERIAL_STEP_EN only) single-step qualifier
//   bus          : bit_serial_seq_if.slave (i_instr, i_start in; o_con_*,
//                  o_busy, o_phase out)
// Optional feature macro: BIT_SERIAL_STEP_EN adds i_step; state advances and
// shift/write/pcincr strobes fire only when i_step=1.
// -----------------------------------------------------------------------------
module bit_serial_seq
    import bit_serial_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ALIGN_ACC   = 3,
    parameter int unsigned ALIGN_GPR_D = 2,
    parameter int unsigned ALIGN_GPR_N = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
`ifdef BIT_SERIAL_STEP_EN
    input  logic           i_step,
`endif
    bit_serial_seq_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic             step;
    opcode_e          op;
    phase_e           phase_q;
    phase_e           phase_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] term_val;
    logic [CNT_W-1:0] align_gpr;
    logic             cnt_term;
    logic             cnt_en;
    logic             cnt_clr;
    ctrl_t            ctrl;

`ifdef BIT_SERIAL_STEP_EN
    assign step = i_step;
`else
    assign step = 1'b1;
`endif

    assign op = opcode_e'(bus.i_instr);

    // Align phase ends on ALIGN_ACC; word phases end on DATA_W-1
    assign term_val  = (phase_q == P1_ALIGN) ? CNT_W'(ALIGN_ACC) : CNT_W'(DATA_W - 1);
    assign align_gpr = (op == OP_MULN) ? CNT_W'(ALIGN_GPR_N) : CNT_W'(ALIGN_GPR_D);

    bit_serial_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (cnt_clr),
        .i_en       (cnt_en),
        .i_term_val (term_val),
        .o_count    (count),
        .o_term     (cnt_term)
    );

    // Phase register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= P0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Opcode decode: next phase, counter control and raw strobes
    always_comb begin
        phase_d = phase_q;
        ctrl    = '0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;

        case (op)
            OP_WAITS: begin
                ctrl.pcincr = bus.i_start;
                cnt_clr     = 1'b1;
                phase_d     = P0;
            end
            OP_NOP: begin
                ctrl.pcincr = 1'b1;
                cnt_clr     = 1'b1;
                phase_d     = P0;
            end
            OP_WAITR: begin
                ctrl.pcincr = ~bus.i_start;
                cnt_clr     = 1'b1;
                phase_d     = P0;
            end
            OP_ADD, OP_ADD_ALT: begin
                ctrl.gpr_write = 1'b1;
                ctrl.gpr_shift = 1'b1;
                ctrl.acc_shift = 1'b1;
                ctrl.pcincr    = cnt_term;
                cnt_en         = 1'b1;
                if (cnt_term) begin
                    phase_d = P0;
                end
            end
            OP_LDX: begin
                ctrl.mux       = 1'b1;
                ctrl.gpr_write = 1'b1;
                ctrl.gpr_shift = 1'b1;
                ctrl.pcincr    = cnt_term;
                cnt_en         = 1'b1;
                if (cnt_term) begin
                    phase_d = P0;
                end
            end
            OP_MULD, OP_MULN: begin
                cnt_en = 1'b1;
                case (phase_q)
                    P0: begin
                        ctrl.muxalu    = 1'b1;
                        ctrl.gpr_shift = 1'b1;
                        ctrl.gpr_write = 1'b1;
                        ctrl.acc_shift = 1'b1;
                        ctrl.acc_write = 1'b1;
                        if (cnt_term) begin
                            phase_d = P1_ALIGN;
                        end
                    end
                    P1_ALIGN: begin
                        // Shift-only alignment; GPR stops earlier than ACC
                        ctrl.acc_shift = (count < CNT_W'(ALIGN_ACC));
                        ctrl.gpr_shift = (count < align_gpr);
                        if (cnt_term) begin
                            phase_d = P2_ACC;
                        end
                    end
                    P2_ACC: begin
                        ctrl.gpr_shift = 1'b1;
                        ctrl.gpr_write = 1'b1;
                        ctrl.acc_shift = 1'b1;
                        ctrl.acc_write = (op == OP_MULN);
                        if (cnt_term) begin
                            ctrl.pcincr = 1'b1;
                            phase_d     = P0;
                        end
                    end
                    default: begin
                        phase_d = P0;
                    end
                endcase
            end
            default: begin
                phase_d = P0;
            end
        endcase

        // A paused step freezes both the counter and the phase
        cnt_en = cnt_en & step;
        if (!step) begin
            phase_d = phase_q;
        end
    end

    // Output gating: reset forces everything low; step qualifies side effects
    assign bus.o_con_bitsel    = i_rst ? '0 : count;
    assign bus.o_con_mux       = ctrl.mux       & ~i_rst;
    assign bus.o_con_muxalu    = ctrl.muxalu    & ~i_rst;
    assign bus.o_con_gpr_shift = ctrl.gpr_shift & step & ~i_rst;
    assign bus.o_con_gpr_write = ctrl.gpr_write & step & ~i_rst;
    assign bus.o_con_acc_shift = ctrl.acc_shift & step & ~i_rst;
    assign bus.o_con_acc_write = ctrl.acc_write & step & ~i_rst;
    assign bus.o_con_pcincr    = ctrl.pcincr    & step & ~i_rst;
    assign bus.o_busy          = ~i_rst & ((count != '0) || (phase_q != P0));
    assign bus.o_phase         = i_rst ? PHASE_W'(0) : PHASE_W'(phase_q);

`ifndef SYNTHESIS
    // The PC must hold the opcode for the whole instruction
    a_instr_stable: assert property (
        @(posedge i_clk) disable iff (i_rst) bus.o_busy |-> $stable(bus.i_instr)
    ) else $error("bit_serial_seq: i_instr changed while busy");
`endif

endmodule

// File: tb/tb_bit_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_seq
// Self-checking bench for bit_serial_seq. Two instances: defaults (DATA_W=8,
// ALIGN_ACC=3) and a sweep instance (DATA_W=16, ALIGN_ACC=5). Expected outputs
// come from an instruction-level model indexed by executed bit step.
// Honours BIT_SERIAL_STEP_EN when defined.
// -----------------------------------------------------------------------------
module tb_bit_serial_seq;

    typedef struct packed {
        logic [7:0] bitsel;
        logic [1:0] phase;
        logic       busy;
        logic       mux;
        logic       muxalu;
        logic       gs;
        logic       gw;
        logic       as;
        logic       aw;
        logic       pc;
    } obs_t;

    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   dur;

`ifdef BIT_SERIAL_STEP_EN
    logic step_a;
    logic step_b;
    int   step_mode = 0;
    logic step_tog  = 1'b1;
`endif

    always #5 clk = ~clk;

    bit_serial_seq_if #(.DATA_W(8))  ifa ();
    bit_serial_seq_if #(.DATA_W(16)) ifb ();

    bit_serial_seq #(
        .DATA_W(8), .ALIGN_ACC(3), .ALIGN_GPR_D(2), .ALIGN_GPR_N(1)
    ) dut_a (
        .i_clk  (clk),
        .i_rst  (rst),
`ifdef BIT_SERIAL_STEP_EN
        .i_step (step_a),
`endif
        .bus    (ifa.slave)
    );

    bit_serial_seq #(
        .DATA_W(16), .ALIGN_ACC(5), .ALIGN_GPR_D(2), .ALIGN_GPR_N(1)
    ) dut_b (
        .i_clk  (clk),
        .i_rst  (rst),
`ifdef BIT_SERIAL_STEP_EN
        .i_step (step_b),
`endif
        .bus    (ifb.slave)
    );

    // Instruction-level reference: outputs after k executed bit steps
    function automatic obs_t model(input int inst, input logic [2:0] op, input int k,
                                   input logic st, input logic sp);
        obs_t e;
        int dw, aa, gd, gn, len, j;
        e  = '0;
        dw = (inst == 0) ? 8 : 16;
        aa = (inst == 0) ? 3 : 5;
        gd = 2;
        gn = 1;
        case (op)
            3'b000: e.pc = st & sp;
            3'b001: e.pc = sp;
            3'b110: e.pc = ~st & sp;
            3'b100, 3'b101, 3'b111: begin
                e.bitsel = 8'(k);
                e.busy   = (k != 0);
                e.gs     = sp;
                e.gw     = sp;
                if (op == 3'b111) e.mux = 1'b1;
                else              e.as  = sp;
                e.pc     = sp && (k == dw - 1);
            end
            default: begin
                len    = 2 * dw + aa + 1;
                e.busy = (k != 0);
                e.pc   = sp && (k == len - 1);
                if (k < dw) begin
                    e.bitsel = 8'(k);
                    e.muxalu = 1'b1;
                    e.gs = sp; e.gw = sp; e.as = sp; e.aw = sp;
                end else if (k < dw + aa + 1) begin
                    j        = k - dw;
                    e.phase  = 2'd1;
                    e.bitsel = 8'(j);
                    e.as     = sp && (j < aa);
                    e.gs     = sp && (j < ((op == 3'b010) ? gd : gn));
                end else begin
                    j        = k - dw - aa - 1;
                    e.phase  = 2'd2;
                    e.bitsel = 8'(j);
                    e.gs = sp; e.gw = sp; e.as = sp;
                    e.aw = sp && (op == 3'b011);
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic counts(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op[2] && (op != 3'b110));
    endfunction

    function automatic obs_t sample(input int inst);
        obs_t o;
        if (inst == 0) begin
            o.bitsel = 8'(ifa.o_con_bitsel); o.phase = ifa.o_phase; o.busy = ifa.o_busy;
            o.mux = ifa.o_con_mux; o.muxalu = ifa.o_con_muxalu;
            o.gs = ifa.o_con_gpr_shift; o.gw = ifa.o_con_gpr_write;
            o.as = ifa.o_con_acc_shift; o.aw = ifa.o_con_acc_write; o.pc = ifa.o_con_pcincr;
        end else begin
            o.bitsel = 8'(ifb.o_con_bitsel); o.phase = ifb.o_phase; o.busy = ifb.o_busy;
            o.mux = ifb.o_con_mux; o.muxalu = ifb.o_con_muxalu;
            o.gs = ifb.o_con_gpr_shift; o.gw = ifb.o_con_gpr_write;
            o.as = ifb.o_con_acc_shift; o.aw = ifb.o_con_acc_write; o.pc = ifb.o_con_pcincr;
        end
        return o;
    endfunction

    function automatic logic next_step();
`ifdef BIT_SERIAL_STEP_EN
        if (step_mode == 1) begin
            step_tog = ~step_tog;
            return step_tog;
        end
        if (step_mode == 2) return 1'($urandom_range(0, 1));
`endif
        return 1'b1;
    endfunction

    function automatic int dur_scale();
`ifdef BIT_SERIAL_STEP_EN
        if (step_mode == 1) return 2;
`endif
        return 1;
    endfunction

    task automatic drive(input int inst, input logic [2:0] op, input logic st, input logic sp);
        if (inst == 0) begin
            ifa.i_instr = op; ifa.i_start = st;
`ifdef BIT_SERIAL_STEP_EN
            step_a = sp;
`endif
        end else begin
            ifb.i_instr = op; ifb.i_start = st;
`ifdef BIT_SERIAL_STEP_EN
            step_b = sp;
`endif
        end
    endtask

    task automatic check(input string tag, input obs_t o, input obs_t e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    // Run one instruction to its pcincr (or abort after abort_at cycles),
    // checking every cycle, then park on WAITS for one checked cycle.
    // hold >= 0: WAITS sees start=0 / WAITR sees start=1 for hold cycles.
    task automatic run_op(input int inst, input logic [2:0] op, input int hold,
                          input int abort_at, output int d);
        int   k, cyc;
        bit   done;
        logic st, sp;
        obs_t o, e;
        k = 0; cyc = 0; done = 1'b0; d = -1;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            if (hold < 0)           st = 1'($urandom_range(0, 1));
            else if (op == 3'b110)  st = (cyc < hold);
            else                    st = (cyc >= hold);
            sp = next_step();
            drive(inst, op, st, sp);
            #1;
            e = model(inst, op, k, st, sp);
            o = sample(inst);
            check($sformatf("i%0d op%0d k%0d", inst, op, k), o, e);
            cyc++;
            if (o.pc === 1'b1 && d < 0) d = cyc;
            if (e.pc) done = 1'b1;
            else if (counts(op) && sp) k++;
            if (abort_at >= 0 && cyc >= abort_at) return;
        end
        check_int($sformatf("i%0d op%0d complete", inst, op), int'(done), 1);
        @(negedge clk);
        drive(inst, 3'b000, 1'b0, next_step());
        #1;
        check($sformatf("i%0d op%0d after_pcincr", inst, op), sample(inst), '0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 3'b000, 1'b1, 1'b1);
        drive(1, 3'b111, 1'b1, 1'b1);
        #1;
        check("reset_a", sample(0), '0);
        check("reset_b", sample(1), '0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(0, 3'b000, 1'b0, 1'b1);
        drive(1, 3'b000, 1'b0, 1'b1);

        // Directed sequence on the default instance
        run_op(0, 3'b111, -1, -1, dur); check_int("ldx_dur",  dur, 8);
        run_op(0, 3'b010, -1, -1, dur); check_int("muld_dur", dur, 20);
        run_op(0, 3'b011, -1, -1, dur); check_int("muln_dur", dur, 20);
        run_op(0, 3'b100, -1, -1, dur); check_int("add_dur",  dur, 8);
        run_op(0, 3'b101, -1, -1, dur); check_int("add1_dur", dur, 8);
        run_op(0, 3'b000, 5,  -1, dur); check_int("waits_dur", dur, 6);
        run_op(0, 3'b110, 3,  -1, dur); check_int("waitr_dur", dur, 4);
        run_op(0, 3'b001, -1, -1, dur); check_int("nop_dur",  dur, 1);

        // Reset in the middle of MULD P2 (cycle 15 = P2 bit 2)
        run_op(0, 3'b010, -1, 15, dur);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_a", sample(0), '0);
        check_int("reset_mid_no_pc", dur, -1);
        @(posedge clk);
        #2 rst = 1'b0;
        run_op(0, 3'b010, -1, -1, dur); check_int("muld_after_rst", dur, 20);

        // Randomised opcode stream on the default instance
`ifdef BIT_SERIAL_STEP_EN
        step_mode = 2;
`endif
        for (int i = 0; i < 30; i++) begin
            run_op(0, 3'($urandom_range(0, 7)), -1, -1, dur);
        end

        // Parameter sweep instance, stepping every other cycle when enabled
`ifdef BIT_SERIAL_STEP_EN
        step_mode = 1;
        step_tog  = 1'b1;
`endif
        run_op(1, 3'b100, -1, -1, dur); check_int("b_add_dur",  dur, 16 * dur_scale());
`ifdef BIT_SERIAL_STEP_EN
        step_tog = 1'b1;
`endif
        run_op(1, 3'b010, -1, -1, dur); check_int("b_muld_dur", dur, 38 * dur_scale());
`ifdef BIT_SERIAL_STEP_EN
        step_tog = 1'b1;
`endif
        run_op(1, 3'b011, -1, -1, dur); check_int("b_muln_dur", dur, 38 * dur_scale());
`ifdef BIT_SERIAL_STEP_EN
        step_mode = 2;
`endif
        for (int i = 0; i < 10; i++) begin
            run_op(1, 3'($urandom_range(0, 7)), -1, -1, dur);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serial_seq.md
Name: bit_serial_seq

Overview:
Parametrised control sequencer for the bit-serial datapath. It decodes the 3-bit instruction and runs an internal bit counter and phase FSM. It drives the mux, ALU-mux, GPR/ACC shift/write and PC-increment controls. Word width and multiply alignment lengths are generic, and the block owns its own bit counter instead of taking an external count.

Parameters:
DATA_W, 8, serial word length in bits (>=2); one word op = DATA_W bit cycles
ALIGN_ACC, 3, ACC shift cycles in multiply align phase (1..DATA_W-1); align phase lasts ALIGN_ACC+1 cycles
ALIGN_GPR_D, 2, GPR shift cycles in align phase for MULD (<=ALIGN_ACC)
ALIGN_GPR_N, 1, GPR shift cycles in align phase for MULN (<=ALIGN_ACC)
CNT_W, $clog2(DATA_W), bit-counter width (derived, not overridden)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_instr  in  3  current opcode; held stable by the PC until after o_con_pcincr
i_start  in  1  start/handshake switch
o_con_bitsel  out  CNT_W  bit index for the input-switch mux (equals count)
o_con_mux  out  1  GPR source select: 1 = external input bit
o_con_muxalu  out  1  ALU input select
o_con_gpr_shift  out  1  GPR shift enable
o_con_gpr_write  out  1  GPR serial write enable
o_con_acc_shift  out  1  ACC shift enable
o_con_acc_write  out  1  ACC serial write enable
o_con_pcincr  out  1  advance PC at next edge
o_busy  out  1  high while count!=0 or phase!=P0
o_phase  out  2  current phase (debug)

Behaviour:
- State: phase {P0, P1_ALIGN, P2_ACC} and count[CNT_W-1:0]. Both are cleared asynchronously by i_rst to P0/0.
- All control outputs are combinational from (phase, count, i_instr, i_start). They are forced to 0 while i_rst is high.
- Terminal cycle: count==DATA_W-1 in P0/P2, or count==ALIGN_ACC in P1. At a terminal cycle, count goes to 0 next edge. Otherwise count increments every cycle in which the opcode is executing.
- 000 WAITS, P0: count held at 0. pcincr=1 when i_start=1, otherwise all outputs 0.
- 001 NOP: pcincr=1 in first cycle; count stays 0.
- 110 WAITR: pcincr=1 when i_start=0, otherwise idle.
- 10? ADD: gpr_write, gpr_shift and acc_shift asserted for DATA_W cycles. pcincr on terminal cycle.
- 111 LDX: mux, gpr_write and gpr_shift asserted for DATA_W cycles. pcincr on terminal cycle.
- 010 MULD / 011 MULN, three phases:
  - P0: muxalu, gpr_shift, gpr_write, acc_shift and acc_write asserted for DATA_W cycles. Terminal cycle moves to P1_ALIGN.
  - P1_ALIGN: acc_shift asserted while count<ALIGN_ACC. gpr_shift asserted while count<ALIGN_GPR_D (MULD) or count<ALIGN_GPR_N (MULN). No writes. Terminal cycle moves to P2_ACC.
  - P2_ACC: gpr_shift, gpr_write and acc_shift asserted for DATA_W cycles; acc_write asserted only for MULN. Terminal cycle asserts pcincr and moves to P0.
- pcincr is asserted for exactly one cycle per instruction. Phase is always P0 and count 0 in the cycle after pcincr.
- If i_instr changes while o_busy=1, that is a protocol violation: a simulation assertion fires. Hardware behaviour is unspecified except that the FSM returns to P0 on the next terminal cycle.
- Reset mid-operation: the instruction is abandoned with no pcincr. The block restarts from P0/0 in the first cycle after reset deasserts.
- Bit-cycle throughput: an ADD/LDX takes DATA_W cycles; a multiply takes 2*DATA_W+ALIGN_ACC+1 cycles.

Optional Feature:
Macro BIT_SERIAL_STEP_EN.
- Defined: adds input port i_step (1 bit). Count and phase advance only in cycles where i_step=1. Every shift, write and pcincr output is ANDed with i_step, giving single-step debugging from a switch.
- Undefined: no i_step port; behaves as if i_step is constantly 1.

Decomposition:
- Package bit_serial_pkg: opcode enum (OP_WAITS=000, OP_NOP=001, OP_MULD=010, OP_MULN=011, OP_ADD=10?, OP_WAITR=110, OP_LDX=111) and the phase enum.
- One sub-module, bit_serial_cnt: counter with async reset, sync clear, enable and a terminal-value input; outputs count and a terminal flag.

Test Plan (DATA_W=8, defaults):
- Reset: assert i_rst mid-MULD P2 -> all outputs 0 immediately; after release o_phase=0, o_con_bitsel=0, no pcincr.
- LDX: opcode 111 -> mux, gpr_write and gpr_shift high for 8 cycles; o_con_bitsel sequence 0..7; pcincr only at bitsel=7.
- MULD: opcode 010 -> 8 cycles P0 with acc_write; align gpr_shift at count 0,1 and acc_shift at count 0,1,2; 8 cycles P2 without acc_write; pcincr at cycle 20.
- MULN: opcode 011 -> align gpr_shift only at count 0; acc_write high throughout P2; pcincr at cycle 20.
- WAITS then WAITR: i_start=0 gives no pcincr for 5 cycles; raise i_start -> pcincr same cycle. Under WAITR, i_start=1 holds; drop it -> pcincr.
- Param sweep: DATA_W=16, ALIGN_ACC=5 -> ADD lasts 16 cycles; multiply pcincr at cycle 38. Repeat with BIT_SERIAL_STEP_EN and i_step toggling every other cycle -> durations double.
